// File: rtl/open_loop_flow_sched_if.sv
// Handshake bundle between the flow scheduler and its neighbours: setup and
// notification decoders on the input side, buffer engine and retire sink on the
// output side, plus the free-running statistics counters.
//   slave  : scheduler view (consumes setup/notif, produces req/done/stat)
//   master : environment view (drives setup/notif, consumes req/done/stat)
interface open_loop_flow_sched_if #(
  parameter int FLOWID_W = 8,
  parameter int CNT_W    = 32
);
  // flow setup
  logic                setup_val;
  logic [FLOWID_W-1:0] setup_flowid;
  logic [CNT_W-1:0]    setup_total_reqs;
  logic [CNT_W-1:0]    setup_bufsize;
  logic [7:0]          setup_dir;
  logic [7:0]          setup_copy;
  logic                setup_rdy;
  // ready notification
  logic                notif_val;
  logic [FLOWID_W-1:0] notif_flowid;
  logic                notif_rdy;
  // buffer request
  logic                req_val;
  logic [FLOWID_W-1:0] req_flowid;
  logic [CNT_W-1:0]    req_len;
  logic [7:0]          req_dir;
  logic [7:0]          req_copy;
  logic                req_rdy;
  // flow retired
  logic                done_val;
  logic [FLOWID_W-1:0] done_flowid;
  logic                done_rdy;
  // statistics
  logic [CNT_W-1:0]    stat_reqs;
  logic [CNT_W-1:0]    stat_drops;

  modport slave (
    input  setup_val, setup_flowid, setup_total_reqs, setup_bufsize, setup_dir, setup_copy,
    output setup_rdy,
    input  notif_val, notif_flowid,
    output notif_rdy,
    output req_val, req_flowid, req_len, req_dir, req_copy,
    input  req_rdy,
    output done_val, done_flowid,
    input  done_rdy,
    output stat_reqs, stat_drops
  );

  modport master (
    output setup_val, setup_flowid, setup_total_reqs, setup_bufsize, setup_dir, setup_copy,
    input  setup_rdy,
    output notif_val, notif_flowid,
    input  notif_rdy,
    input  req_val, req_flowid, req_len, req_dir, req_copy,
    output req_rdy,
    input  done_val, done_flowid,
    output done_rdy,
    input  stat_reqs, stat_drops
  );
endinterface

// File: rtl/open_loop_flow_sched.sv
// Purpose : per-flow request scheduler; one buffer request per ready notification, retires flows after total_reqs.
// Latency : notif accept -> req_val 2 cycles; setup with total_reqs==0 -> done_val next cycle.
// Backpressure: one flow in flight; setup/notif rdy only in IDLE, req/done held until their rdy.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : open_loop_flow_sched_if.slave (setup, notif, req, done, stat_reqs, stat_drops)
module open_loop_flow_sched #(
  parameter int FLOWID_W = 8,
  parameter int CNT_W    = 32
) (
  input logic                   clk,
  input logic                   rst,
  open_loop_flow_sched_if.slave bus
);

  localparam int DEPTH = 1 << FLOWID_W;

  typedef struct packed {
    logic [CNT_W-1:0] total;
    logic [CNT_W-1:0] bufsize;
    logic [CNT_W-1:0] curr;
    logic [7:0]       dir;
    logic [7:0]       copy;
  } ctx_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_ISSUE = 3'd2,
    S_WB    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  ctx_t                r_ctx_mem [DEPTH];
  ctx_t                r_rd_dat;     // registered table read
  ctx_t                r_ctx;        // context of the flow in flight
  logic [FLOWID_W-1:0] r_flowid;
  logic [DEPTH-1:0]    r_active;     // kept in flops so reset can clear every flow at once
  logic [CNT_W-1:0]    r_stat_reqs;
  logic [CNT_W-1:0]    r_stat_drops;

  logic                w_setup_acc;
  logic                w_notif_acc;
  logic                w_notif_hit;
  logic                w_req_acc;
  logic                w_last;
  logic                w_mem_we;
  logic                w_mem_rd;
  logic [FLOWID_W-1:0] w_mem_waddr;
  ctx_t                w_mem_wdat;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    bus.setup_rdy = 1'b0;
    bus.notif_rdy = 1'b0;
    bus.req_val   = 1'b0;
    bus.done_val  = 1'b0;
    w_setup_acc   = 1'b0;
    w_notif_acc   = 1'b0;
    w_notif_hit   = 1'b0;
    w_req_acc     = 1'b0;
    w_mem_we      = 1'b0;
    w_mem_rd      = 1'b0;
    w_mem_waddr   = r_flowid;
    w_mem_wdat    = r_ctx;
    // curr was already advanced on the request handshake, so this is curr_next==total
    w_last        = (r_ctx.curr == r_ctx.total);

    case (r_state)
      S_IDLE: begin
        // rdy is held low while reset is asserted even though the state is IDLE
        bus.setup_rdy = !rst;
        bus.notif_rdy = !rst && !bus.setup_val;
        w_setup_acc   = !rst && bus.setup_val;
        w_notif_acc   = !rst && !bus.setup_val && bus.notif_val;
        w_notif_hit   = w_notif_acc && r_active[bus.notif_flowid];
        if (w_setup_acc) begin
          w_mem_we           = 1'b1;
          w_mem_waddr        = bus.setup_flowid;
          w_mem_wdat.total   = bus.setup_total_reqs;
          w_mem_wdat.bufsize = bus.setup_bufsize;
          w_mem_wdat.curr    = '0;
          w_mem_wdat.dir     = bus.setup_dir;
          w_mem_wdat.copy    = bus.setup_copy;
          if (bus.setup_total_reqs == '0) begin
            w_state_nxt = S_DONE;
          end
        end else if (w_notif_hit) begin
          w_mem_rd    = 1'b1;
          w_state_nxt = S_RD;
        end
      end
      S_RD: begin
        w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        bus.req_val = 1'b1;
        w_req_acc   = bus.req_rdy;
        if (bus.req_rdy) begin
          w_state_nxt = S_WB;
        end
      end
      S_WB: begin
        w_mem_we    = 1'b1;
        w_state_nxt = w_last ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        bus.done_val = 1'b1;
        if (bus.done_rdy) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Context table: single write port, registered read
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_ctx_mem[w_mem_waddr] <= w_mem_wdat;
    end
    if (w_mem_rd) begin
      r_rd_dat <= r_ctx_mem[bus.notif_flowid];
    end
  end

  // ---------------------------------------------------------------------------
  // In-flight flow, active bits, statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flowid     <= '0;
      r_ctx        <= '0;
      r_active     <= '0;
      r_stat_reqs  <= '0;
      r_stat_drops <= '0;
    end else begin
      if (w_setup_acc) begin
        r_flowid                   <= bus.setup_flowid;
        r_active[bus.setup_flowid] <= (bus.setup_total_reqs != '0);
      end
      if (w_notif_acc) begin
        if (w_notif_hit) begin
          r_flowid <= bus.notif_flowid;
        end else begin
          r_stat_drops <= r_stat_drops + CNT_W'(1);
        end
      end
      if (r_state == S_RD) begin
        r_ctx <= r_rd_dat;
      end
      if (w_req_acc) begin
        r_ctx.curr  <= r_ctx.curr + CNT_W'(1);
        r_stat_reqs <= r_stat_reqs + CNT_W'(1);
      end
      if (r_state == S_WB && w_last) begin
        r_active[r_flowid] <= 1'b0;
      end
    end
  end

  assign bus.req_flowid  = r_flowid;
  assign bus.req_len     = r_ctx.bufsize;
  assign bus.req_dir     = r_ctx.dir;
  assign bus.req_copy    = r_ctx.copy;
  assign bus.done_flowid = r_flowid;
  assign bus.stat_reqs   = r_stat_reqs;
  assign bus.stat_drops  = r_stat_drops;

endmodule

// File: tb/tb_open_loop_flow_sched.sv
// Directed bench for open_loop_flow_sched: table of per-flow scenarios plus
// hand-written sequences for priority, stall, reset and a 16-flow interleave.
module tb_open_loop_flow_sched;

  localparam int FW = 8;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  open_loop_flow_sched_if #(.FLOWID_W(FW), .CNT_W(CW)) bus ();

  open_loop_flow_sched #(.FLOWID_W(FW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // expected per-flow request fields and observed handshake counts
  logic [31:0] m_len  [256];
  logic [7:0]  m_dir  [256];
  logic [7:0]  m_copy [256];
  int          req_cnt  [256];
  int          done_cnt [256];
  logic [7:0]  mon_f;

  // handshakes sampled on the falling edge; they complete at the next rising edge
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req_val && bus.req_rdy) begin
        mon_f = bus.req_flowid;
        req_cnt[mon_f]++;
        check("req_len",  {32'd0, bus.req_len},  {32'd0, m_len[mon_f]});
        check("req_dir",  {56'd0, bus.req_dir},  {56'd0, m_dir[mon_f]});
        check("req_copy", {56'd0, bus.req_copy}, {56'd0, m_copy[mon_f]});
      end
      if (bus.done_val && bus.done_rdy) begin
        done_cnt[bus.done_flowid]++;
      end
    end
  end

  task automatic do_setup(input logic [7:0] f, input logic [31:0] tot, input logic [31:0] bsz,
                          input logic [7:0] dir, input logic [7:0] cp);
    bit ok = 0;
    m_len[f] = bsz; m_dir[f] = dir; m_copy[f] = cp;
    @(posedge clk); #1;
    bus.setup_flowid = f; bus.setup_total_reqs = tot; bus.setup_bufsize = bsz;
    bus.setup_dir = dir; bus.setup_copy = cp; bus.setup_val = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.setup_rdy) ok = 1;
    end
    @(posedge clk); #1;
    bus.setup_val = 1'b0;
    check("setup_accepted", ok, 1);
  endtask

  task automatic do_notif(input logic [7:0] f);
    bit ok = 0;
    @(posedge clk); #1;
    bus.notif_flowid = f; bus.notif_val = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.notif_rdy) ok = 1;
    end
    @(posedge clk); #1;
    bus.notif_val = 1'b0;
    check("notif_accepted", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.setup_rdy) ok = 1;
    end
    check("reach_idle", ok, 1);
  endtask

  typedef struct {
    logic [7:0]  fid;
    logic [31:0] total;
    logic [31:0] bufsz;
    logic [7:0]  dir;
    logic [7:0]  copy;
    int          n_notif;
    int          exp_reqs;
    int          exp_done;
    int          exp_drops;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int r0, d0, dr0, lat;
    bit stable;
    logic [31:0] tot6 [16];
    int rem [16];
    int left, drops6, k;

    bus.setup_val = 0; bus.setup_flowid = 0; bus.setup_total_reqs = 0; bus.setup_bufsize = 0;
    bus.setup_dir = 0; bus.setup_copy = 0; bus.notif_val = 0; bus.notif_flowid = 0;
    bus.req_rdy = 1; bus.done_rdy = 1;

    //            fid    total  bufsize        dir   copy  notifs reqs done drops
    vecs[0] = '{8'd3,   32'd2, 32'd1024,      8'd0, 8'd0, 3,     2,   1,   1};
    vecs[1] = '{8'd5,   32'd0, 32'd64,        8'd0, 8'd0, 1,     0,   1,   1};
    vecs[2] = '{8'd0,   32'd1, 32'd0,         8'd1, 8'd1, 1,     1,   1,   0};
    vecs[3] = '{8'd255, 32'd3, 32'hFFFF_FFFF, 8'd1, 8'd0, 2,     2,   0,   0};
    vecs[4] = '{8'd255, 32'd1, 32'd7,         8'd0, 8'd1, 2,     1,   1,   1};
    vecs[5] = '{8'd3,   32'd1, 32'd16,        8'd1, 8'd1, 1,     1,   1,   0};

    // reset state
    #23;
    check("rst_setup_rdy", bus.setup_rdy, 0);
    check("rst_notif_rdy", bus.notif_rdy, 0);
    check("rst_req_val",   bus.req_val, 0);
    check("rst_done_val",  bus.done_val, 0);
    check("rst_stat_reqs", bus.stat_reqs, 0);
    check("rst_stat_drops", bus.stat_drops, 0);
    check("rst_req_len",   bus.req_len, 0);
    check("rst_req_flowid", bus.req_flowid, 0);
    @(negedge clk); rst = 1'b0;

    // table-driven flow scenarios
    for (int v = 0; v < 6; v++) begin
      r0 = req_cnt[vecs[v].fid]; d0 = done_cnt[vecs[v].fid]; dr0 = int'(bus.stat_drops);
      do_setup(vecs[v].fid, vecs[v].total, vecs[v].bufsz, vecs[v].dir, vecs[v].copy);
      wait_idle();
      for (int n = 0; n < vecs[v].n_notif; n++) begin
        do_notif(vecs[v].fid);
        wait_idle();
      end
      check($sformatf("v%0d_reqs", v),  req_cnt[vecs[v].fid] - r0, vecs[v].exp_reqs);
      check($sformatf("v%0d_done", v),  done_cnt[vecs[v].fid] - d0, vecs[v].exp_done);
      check($sformatf("v%0d_drops", v), int'(bus.stat_drops) - dr0, vecs[v].exp_drops);
      if (v == 0) begin
        check("v0_stat_reqs", bus.stat_reqs, 2);
        check("v0_stat_drops", bus.stat_drops, 1);
      end
    end
    check("tbl_stat_reqs", bus.stat_reqs, 7);
    check("tbl_stat_drops", bus.stat_drops, 3);

    // zero-request flow retires within 2 cycles of setup
    do_setup(8'd6, 32'd0, 32'd32, 8'd0, 8'd0);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      if (bus.done_val && bus.done_flowid == 8'd6) lat = i;
      else @(negedge clk);
    end
    check("zero_total_done_within_2", (lat >= 1 && lat <= 2), 1);
    wait_idle();

    // setup and notif in the same cycle: setup wins, notif taken next IDLE cycle
    do_setup(8'd1, 32'd2, 32'd100, 8'd0, 8'd0);
    wait_idle();
    m_len[2] = 32'd200; m_dir[2] = 8'd1; m_copy[2] = 8'd0;
    @(posedge clk); #1;
    bus.setup_flowid = 8'd2; bus.setup_total_reqs = 32'd1; bus.setup_bufsize = 32'd200;
    bus.setup_dir = 8'd1; bus.setup_copy = 8'd0; bus.setup_val = 1'b1;
    bus.notif_flowid = 8'd1; bus.notif_val = 1'b1;
    @(negedge clk);
    check("prio_setup_rdy", bus.setup_rdy, 1);
    check("prio_notif_rdy", bus.notif_rdy, 0);
    @(posedge clk); #1; bus.setup_val = 1'b0;
    @(negedge clk);
    check("prio_notif_rdy_next", bus.notif_rdy, 1);
    @(posedge clk); #1; bus.notif_val = 1'b0;
    wait_idle();
    check("prio_f1_req", req_cnt[1], 1);
    do_notif(8'd1); wait_idle();
    do_notif(8'd2); wait_idle();
    check("prio_f1_done", done_cnt[1], 1);
    check("prio_f2_done", done_cnt[2], 1);
    check("prio_f2_req", req_cnt[2], 1);

    // request stalled for 20 cycles, 2-cycle notif->req latency
    do_setup(8'd7, 32'd1, 32'd55, 8'd0, 8'd1);
    wait_idle();
    bus.req_rdy = 1'b0;
    do_notif(8'd7);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (bus.req_val) lat = i;
    end
    check("notif_to_req_latency", lat, 2);
    stable = 1;
    for (int i = 0; i < 20; i++) begin
      if (!(bus.req_val && bus.req_flowid == 8'd7 && bus.req_len == 32'd55 &&
            bus.req_copy == 8'd1 && bus.req_dir == 8'd0 && !bus.notif_rdy)) stable = 0;
      @(negedge clk);
    end
    check("stall_fields_stable", stable, 1);
    bus.req_rdy = 1'b1;
    wait_idle();
    check("stall_f7_req", req_cnt[7], 1);
    check("stall_f7_done", done_cnt[7], 1);

    // asynchronous reset while a request is pending
    do_setup(8'd9, 32'd2, 32'd8, 8'd1, 8'd0);
    wait_idle();
    bus.req_rdy = 1'b0;
    do_notif(8'd9);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (bus.req_val) lat = i;
    end
    check("rst_mid_req_seen", lat != 0, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_req_val", bus.req_val, 0);
    check("async_rst_stat_reqs", bus.stat_reqs, 0);
    check("async_rst_setup_rdy", bus.setup_rdy, 0);
    @(negedge clk); rst = 1'b0; bus.req_rdy = 1'b1;
    r0 = req_cnt[9];
    do_notif(8'd9);
    wait_idle();
    check("post_rst_drop", bus.stat_drops, 1);
    check("post_rst_no_req", req_cnt[9] - r0, 0);

    // 16 RECV copy flows, notifications in random order
    for (int i = 0; i < 16; i++) begin
      tot6[i] = 32'($urandom_range(1, 4));
      rem[i]  = int'(tot6[i]);
      do_setup(8'(16 + i), tot6[i], 32'($urandom_range(1, 4096)), 8'd1, 8'd1);
      wait_idle();
    end
    dr0 = int'(bus.stat_drops);
    drops6 = 0;
    left = 0;
    for (int i = 0; i < 16; i++) left += rem[i];
    for (int it = 0; it < 400 && left > 0; it++) begin
      k = $urandom_range(0, 15);
      if (rem[k] > 0) begin
        rem[k]--; left--;
      end else begin
        drops6++;
      end
      do_notif(8'(16 + k));
      wait_idle();
    end
    for (int i = 0; i < 16; i++) begin
      check($sformatf("mix_f%0d_reqs", 16 + i), req_cnt[16 + i], tot6[i]);
      check($sformatf("mix_f%0d_done", 16 + i), done_cnt[16 + i], 1);
    end
    check("mix_drops", int'(bus.stat_drops) - dr0, drops6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
